// File: rtl/aesl_deadlock_param_monitor_if.sv
// Signal bundle between a dataflow region's stall/idle taps and the deadlock monitor.
// master drives the raw stall/idle taps; slave (the monitor) returns the deadlock report.
interface aesl_deadlock_param_monitor_if #(
    parameter int N_PROC = 3,
    parameter int N_CH   = 2,
    parameter int DUR_W  = 16
);
    localparam int FC_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]   chan_full_block;
    logic [N_CH-1:0]   chan_empty_block;
    logic [N_PROC-1:0] inst_idle_sigs;
    logic [N_PROC-1:0] inst_block_sigs;

    logic              block;
    logic [2*N_CH-1:0] axis_block_info;
    logic [FC_W-1:0]   first_chan;
    logic [DUR_W-1:0]  block_cycles;

    modport master (
        output chan_full_block,
        output chan_empty_block,
        output inst_idle_sigs,
        output inst_block_sigs,
        input  block,
        input  axis_block_info,
        input  first_chan,
        input  block_cycles
    );

    modport slave (
        input  chan_full_block,
        input  chan_empty_block,
        input  inst_idle_sigs,
        input  inst_block_sigs,
        output block,
        output axis_block_info,
        output first_chan,
        output block_cycles
    );
endinterface

// File: rtl/aesl_deadlock_param_monitor.sv
// Declares a dataflow deadlock once processes are all idle/blocked with a stalled channel for THRESHOLD cycles; AESL_DEADLOCK_STICKY_EN makes DEADLOCK terminal.
// Latency: block rises after the THRESHOLD-th consecutive edge sampling the raw condition; all outputs registered.
// Backpressure: none; pure observer, never stalls or drives the monitored region.
module aesl_deadlock_param_monitor #(
    parameter int N_PROC    = 3,
    parameter int N_CH      = 2,
    parameter int THRESHOLD = 4,
    parameter int DUR_W     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    aesl_deadlock_param_monitor_if.slave  mon
);
    localparam int FC_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (THRESHOLD > 0) ? $clog2(THRESHOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              raw;
    logic [N_CH-1:0]   chan_stall;
    logic [2*N_CH-1:0] snap;
    logic [FC_W-1:0]   first_idx;
    logic              enter_dl;
    logic              stay_dl;

    logic              block_q;
    logic [2*N_CH-1:0] info_q;
    logic [FC_W-1:0]   first_chan_q;
    logic [DUR_W-1:0]  block_cycles_q;

    assign chan_stall = mon.chan_full_block | mon.chan_empty_block;

    // Pure process hangs (no stalled channel) are deliberately excluded.
    assign raw = (&(mon.inst_block_sigs | mon.inst_idle_sigs))
               & (|mon.inst_block_sigs)
               & (|chan_stall);

    always_comb begin
        snap = '0;
        for (int k = 0; k < N_CH; k++) begin
            snap[2*k+1] = mon.chan_full_block[k];
            snap[2*k]   = mon.chan_empty_block[k];
        end
    end

    // Downward scan so the lowest stalled index wins.
    always_comb begin
        first_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (chan_stall[k]) begin
                first_idx = FC_W'(k);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (raw) begin
                    if (THRESHOLD <= 1) begin
                        state_d = ST_DEADLOCK;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_SUSPECT;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_SUSPECT: begin
                if (!raw) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DEADLOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DEADLOCK: begin
                cnt_d = '0;
`ifdef AESL_DEADLOCK_STICKY_EN
                state_d = ST_DEADLOCK;
`else
                if (!raw) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign enter_dl = (state_q != ST_DEADLOCK) && (state_d == ST_DEADLOCK);
    assign stay_dl  = (state_q == ST_DEADLOCK) && (state_d == ST_DEADLOCK);

    // Snapshot is taken from the same edge that completes qualification.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            block_q        <= 1'b0;
            info_q         <= '0;
            first_chan_q   <= '0;
            block_cycles_q <= '0;
        end else if (enter_dl) begin
            block_q        <= 1'b1;
            info_q         <= snap;
            first_chan_q   <= first_idx;
            block_cycles_q <= DUR_W'(1);
        end else if (stay_dl) begin
            block_q <= 1'b1;
            if (block_cycles_q != {DUR_W{1'b1}}) begin
                block_cycles_q <= block_cycles_q + DUR_W'(1);
            end
        end else begin
            block_q        <= 1'b0;
            info_q         <= '0;
            first_chan_q   <= '0;
            block_cycles_q <= '0;
        end
    end

    assign mon.block           = block_q;
    assign mon.axis_block_info = info_q;
    assign mon.first_chan      = first_chan_q;
    assign mon.block_cycles    = block_cycles_q;

endmodule

// File: doc/aesl_deadlock_param_monitor.md
# aesl_deadlock_param_monitor

Parametrised deadlock monitor for the co-simulation bench of a dataflow region. It generalises the fixed per-region monitors to N_PROC processes and N_CH AXI-stream channels. A channel block must persist for THRESHOLD cycles before deadlock is declared; it captures a per-channel snapshot, the first blocked channel index and the deadlock duration. It sits beside the DUT instance in the generated testbench and feeds the bench's deadlock report.

## Interface
- N_PROC, 3, number of dataflow processes monitored (>=1)
- N_CH, 2, number of AXI-stream channels monitored (>=1)
- THRESHOLD, 4, consecutive cycles the raw condition must hold before declaring (>=1)
- DUR_W, 16, width of duration counter
- clock  input  1  sole clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- chan_full_block  input  N_CH  channel k writer stalled on full
- chan_empty_block  input  N_CH  channel k reader stalled on empty
- inst_idle_sigs  input  N_PROC  process p idle
- inst_block_sigs  input  N_PROC  process p blocked on a channel
- block  output  1  deadlock declared
- axis_block_info  output  2*N_CH  bits [2k+1:2k] = {full,empty} of channel k latched at detection; 0 when block=0
- first_chan  output  max(1,$clog2(N_CH))  lowest-index channel with any block bit at detection; 0 when block=0
- block_cycles  output  DUR_W  cycles spent in DEADLOCK, saturating at all-ones

## Operation
- raw = &(inst_block_sigs | inst_idle_sigs) & |inst_block_sigs & |(chan_full_block | chan_empty_block); all processes idle or blocked, at least one blocked, at least one channel stalled.
- Persistence counter cnt, width $clog2(THRESHOLD+1), counts consecutive cycles raw=1.
- FSM states: IDLE, SUSPECT, DEADLOCK.
  - IDLE: raw=1 and THRESHOLD=1 -> DEADLOCK; raw=1 otherwise -> SUSPECT, cnt=1; raw=0 stays, cnt=0.
  - SUSPECT: raw=0 -> IDLE, cnt=0; raw=1 and cnt==THRESHOLD-1 -> DEADLOCK; else cnt+1.
  - DEADLOCK: behaviour per Configuration.
- On the DEADLOCK entry edge: snapshot {chan_full_block[k],chan_empty_block[k]} into info for all k. Load first_chan from the sampled inputs of that edge. Load block_cycles=1.
- In DEADLOCK, block_cycles increments each cycle and saturates at 2^DUR_W-1, with no wrap. Info and first_chan stay frozen.
- Any single-cycle drop of raw in SUSPECT restarts qualification from zero.
- No channel stalled but all processes blocked gives raw=0; this is a pure process hang and is not reported by this block.

## Timing
- Reset (reset=0, async): state IDLE, cnt=0, block=0, axis_block_info=0, first_chan=0, block_cycles=0. Assertion mid-operation clears immediately, without waiting for a clock edge. Deassertion is honoured at the next rising edge.
- Latency: with raw=1 sampled at edges 1..THRESHOLD, block rises after edge THRESHOLD. For THRESHOLD=1 this is one cycle after raw.
- All outputs are registered; no combinational path from inputs to outputs.
- Exit: in non-sticky mode, raw=0 sampled in DEADLOCK gives block=0 and info/first_chan/block_cycles=0 after that edge. State returns to IDLE with cnt=0.
- If raw drops and reasserts on consecutive edges, re-entry requires full THRESHOLD qualification again.

## Configuration
- AESL_DEADLOCK_STICKY_EN defined: DEADLOCK is terminal until reset. block stays 1, snapshot stays frozen and block_cycles keeps counting and saturating, regardless of raw.
- Not defined: DEADLOCK exits to IDLE when raw=0, as described under Timing.

## Test plan
- N_PROC=3, N_CH=2, THRESHOLD=4: inst_block=3'b001, idle=3'b110, chan_full=2'b10 held 4 edges -> block=1 after edge 4, axis_block_info=4'b1000, first_chan=1, block_cycles=1.
- Same stimulus held 3 edges, then idle=3'b000 for 1 edge, then reapplied -> block stays 0 until 4 further edges.
- THRESHOLD=1, chan_empty=2'b01, inst_block=3'b111 -> block=1 one edge later, info=4'b0001, first_chan=0.
- DUR_W=4, deadlock held 20 cycles -> block_cycles reaches 15 and stays 15.
- Non-sticky: in DEADLOCK drop all chan sigs -> next edge block=0, info=0, block_cycles=0. Sticky build: same stimulus -> block remains 1.
- reset pulled low asynchronously mid-SUSPECT and mid-DEADLOCK -> all outputs 0 before the next edge. After release, qualification restarts from cnt=0.
